// File: rtl/onehot_walker.sv
// -----------------------------------------------------------------------------
// onehot_walker
//
// Accepts a burst command (start index, extra length, direction, zero flag)
// and emits a stream of one-hot words that walk from the start bit toward the
// MSB or the LSB, wrapping modulo OUT_W. A zero command emits a single
// all-zero word. Commands are only accepted while idle. There is always one
// idle cycle between the end of one burst and the acceptance of the next.
//
// Ports
//   clk        : single clock, all state updates on the rising edge
//   rst_n      : synchronous active-low reset
//   in_valid   : command present
//   in_ready   : walker is idle and can accept a command
//   in_idx     : start bit position
//   in_len     : words after the first one (burst length = in_len + 1)
//   in_dir     : 0 = walk toward MSB, 1 = walk toward LSB
//   in_zero    : emit a single all-zero word; other in_* fields ignored
//   out_valid  : out_data / out_last are valid
//   out_ready  : consumer accepts the current word
//   out_data   : one-hot word, or all zeros for a zero command
//   out_last   : current word is the final word of its burst
// -----------------------------------------------------------------------------
module onehot_walker #(
  parameter int IDX_W = 3,
  parameter int OUT_W = 2**IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_idx,
  input  logic [IDX_W-1:0] in_len,
  input  logic             in_dir,
  input  logic             in_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last
);

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  localparam logic [IDX_W-1:0] POS_MAX = IDX_W'(OUT_W - 1);
  localparam logic [IDX_W-1:0] POS_ONE = IDX_W'(1);
  localparam logic [OUT_W-1:0] BIT0    = OUT_W'(1);

  state_t           state;
  logic [IDX_W-1:0] pos;   // bit position of the word currently presented
  logic [IDX_W-1:0] rem;   // words still to follow the current one
  logic             dir;
  logic             zero;
  logic [IDX_W-1:0] pos_step;

  // Next bit position, wrapping explicitly so OUT_W need not be a power of two.
  // NOTE: every always_comb output gets a default first so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    pos_step = pos;
    if (dir) begin
      pos_step = (pos == '0) ? POS_MAX : pos - POS_ONE;
    end else begin
      pos_step = (pos == POS_MAX) ? '0 : pos + POS_ONE;
    end
  end

  // Single FSM process; all outputs are registered so nothing downstream sees
  // combinational glitches, including on the reset edge that aborts a burst.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and is tested first, giving it priority over
    // any command or handshake arriving on the same edge.
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      pos       <= '0;
      rem       <= '0;
      dir       <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state     <= EMIT;
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
            pos       <= in_idx;
            rem       <= in_len;
            dir       <= in_dir;
            zero      <= in_zero;
            out_data  <= in_zero ? '0 : (BIT0 << in_idx);
            out_last  <= in_zero || (in_len == '0);
          end
        end

        EMIT: begin
          // in_* is deliberately not looked at here: no command is queued.
          if (out_ready) begin
            if (out_last) begin
              state     <= IDLE;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              out_data  <= '0;
              out_last  <= 1'b0;
            end else begin
              // A zero command is always last, so only one-hot bursts get here.
              rem      <= rem - POS_ONE;
              pos      <= pos_step;
              out_data <= zero ? '0 : (BIT0 << pos_step);
              out_last <= (rem == POS_ONE);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
